// File: rtl/elc3_mem_pkg.sv
// Shared types and defaults for the eLC-3 asynchronous SRAM bus.
package elc3_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_TURN
  } sram_state_t;

  localparam int DEF_ADDR_W  = 20;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_RD_WAIT = 2;
  localparam int DEF_WR_WAIT = 2;
  localparam int DEF_TURN    = 1;

  // Accept-to-accept distance for back-to-back reads.
  function automatic int rd_latency(input int rd_wait);
    return rd_wait + 1;
  endfunction

endpackage

// File: rtl/sram_dq_io.sv
// Tristate wrapper for the SRAM data bus: registered drive enable and drive
// value, plus the combinational read path back into the controller.
module sram_dq_io #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] wdata,
  input  logic              drive_next,
  output logic [DATA_W-1:0] rd_data,
  inout  wire  [DATA_W-1:0] sram_dq
);

  logic              drive_reg;
  logic [DATA_W-1:0] dout_reg;

  // Drive enable follows the controller's next state; data latched on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_reg <= 1'b0;
      dout_reg  <= '0;
    end else begin
      drive_reg <= drive_next;
      if (load) begin
        dout_reg <= wdata;
      end
    end
  end

  assign sram_dq = drive_reg ? dout_reg : 'z;
  assign rd_data = sram_dq;

endmodule

// File: rtl/sram_controller.sv
// Initiator for the eLC-3 asynchronous SRAM: turns a single-outstanding
// req/done handshake into multi-cycle SRAM read and write cycles.
module sram_controller
  import elc3_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_WAIT = DEF_WR_WAIT,
  parameter int TURN    = DEF_TURN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        be,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam int TURN_W   = $clog2(TURN + 1) + 1;

  sram_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [TURN_W-1:0] turn_reg, turn_next;
  logic              done_reg, done_next;
  logic              ce_n_reg, ce_n_next;
  logic              oe_n_reg, oe_n_next;
  logic              we_n_reg, we_n_next;
  logic              lb_n_reg, lb_n_next;
  logic              ub_n_reg, ub_n_next;
  logic              drive_next;
  logic              accept;
  logic              capture;
  logic [1:0]        be_reg;
  logic [1:0]        be_sel;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [DATA_W-1:0] dq_rd;

  // State and wait counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      turn_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      turn_reg  <= turn_next;
    end
  end

  // Next-state logic; one down-counter serves both READ and WR_PULSE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    turn_next  = turn_reg;
    done_next  = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (wr) begin
            state_next = S_WR_SETUP;
          end else begin
            state_next = S_READ;
            cnt_next   = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      S_READ: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_WR_SETUP: begin
        state_next = S_WR_PULSE;
        cnt_next   = CNT_W'(WR_WAIT - 1);
      end
      S_WR_PULSE: begin
        if (cnt_reg == '0) begin
          state_next = S_WR_HOLD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      S_WR_HOLD: begin
        done_next = 1'b1;
        if (TURN == 0) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_TURN;
          turn_next  = TURN_W'(TURN - 1);
        end
      end
      S_TURN: begin
        if (turn_reg == '0) begin
          state_next = S_IDLE;
        end else begin
          turn_next = turn_reg - TURN_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Byte enables come straight from the request on the accept edge.
  assign be_sel = (state_reg == S_IDLE) ? be : be_reg;

  // Strobe values for the state being entered, so strobes leave a register.
  always_comb begin
    ce_n_next  = 1'b1;
    oe_n_next  = 1'b1;
    we_n_next  = 1'b1;
    lb_n_next  = 1'b1;
    ub_n_next  = 1'b1;
    drive_next = 1'b0;
    case (state_next)
      S_READ: begin
        ce_n_next = 1'b0;
        oe_n_next = 1'b0;
        lb_n_next = 1'b0;
        ub_n_next = 1'b0;
      end
      S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
        ce_n_next  = 1'b0;
        we_n_next  = (state_next != S_WR_PULSE);
        lb_n_next  = ~be_sel[0];
        ub_n_next  = ~be_sel[1];
        drive_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered strobes and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_n_reg <= 1'b1;
      oe_n_reg <= 1'b1;
      we_n_reg <= 1'b1;
      lb_n_reg <= 1'b1;
      ub_n_reg <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      ce_n_reg <= ce_n_next;
      oe_n_reg <= oe_n_next;
      we_n_reg <= we_n_next;
      lb_n_reg <= lb_n_next;
      ub_n_reg <= ub_n_next;
      done_reg <= done_next;
    end
  end

  // Address/byte enables latched on accept; read data captured at the end of READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      be_reg    <= '0;
      rdata_reg <= '0;
    end else begin
      if (accept) begin
        addr_reg <= addr;
        be_reg   <= be;
      end
      if (capture) begin
        rdata_reg <= dq_rd;
      end
    end
  end

  sram_dq_io #(
    .DATA_W(DATA_W)
  ) u_dq_io (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept & wr),
    .wdata      (wdata),
    .drive_next (drive_next),
    .rd_data    (dq_rd),
    .sram_dq    (sram_dq)
  );

  assign ready     = (state_reg == S_IDLE);
  assign done      = done_reg;
  assign rdata     = rdata_reg;
  assign sram_ce_n = ce_n_reg;
  assign sram_oe_n = oe_n_reg;
  assign sram_we_n = we_n_reg;
  assign sram_lb_n = lb_n_reg;
  assign sram_ub_n = ub_n_reg;
  assign sram_addr = addr_reg;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a FakeMemory-style SRAM responder.
module tb_sram_controller;
  import elc3_mem_pkg::*;

  localparam int AW  = DEF_ADDR_W;
  localparam int DW  = DEF_DATA_W;
  localparam int RDW = DEF_RD_WAIT;
  localparam int WRW = DEF_WR_WAIT;
  localparam int TRN = DEF_TURN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [1:0]    be = 2'b00;
  logic          ready, done;
  logic [DW-1:0] rdata;
  logic          ce_n, oe_n, we_n, lb_n, ub_n;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;

  sram_controller #(
    .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_WAIT(WRW), .TURN(TRN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .be(be), .ready(ready), .done(done), .rdata(rdata),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_lb_n(lb_n), .sram_ub_n(ub_n), .sram_addr(sram_addr), .sram_dq(sram_dq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    return 16'((i * 257) ^ 16'h5A3C);
  endfunction

  // ---------------- FakeMemory responder ----------------
  logic [DW-1:0] fmem [0:255];
  bit            init_done = 1'b0;
  wire           fake_drive = !ce_n && !oe_n && we_n;
  assign sram_dq = fake_drive ? fmem[sram_addr[7:0]] : 16'bz;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) fmem[i] <= init_val(i);
      init_done <= 1'b1;
    end else if (!ce_n && !we_n) begin
      if (!lb_n) fmem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) fmem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  // ---------------- Scoreboard ----------------
  typedef struct {
    bit          w;
    logic [15:0] data;
    logic [1:0]  be;
    int unsigned done_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model [0:255];
  int          oe_cnt = 0;
  int          we_cnt = 0;
  logic        exp_lb, exp_ub;

  // Monitor: strobe shape, lane enables, no contention, and Done against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      oe_cnt = 0;
      we_cnt = 0;
    end else begin
      if (!oe_n) begin
        oe_cnt++;
        chk("no_dq_drive_while_oe", {31'b0, dut.u_dq_io.drive_reg}, 32'd0);
      end
      if (!we_n) we_cnt++;
      if (!ce_n && oe_n && sb.size() > 0 && sb[0].w) begin
        exp_lb = ~sb[0].be[0];
        exp_ub = ~sb[0].be[1];
        chk("write_lb_n", {31'b0, lb_n}, {31'b0, exp_lb});
        chk("write_ub_n", {31'b0, ub_n}, {31'b0, exp_ub});
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", {31'b0, done}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", cyc, mon_e.done_cyc);
          if (mon_e.w) begin
            chk("we_low_cycles", we_cnt, WRW);
          end else begin
            chk("rdata", {16'b0, rdata}, {16'b0, mon_e.data});
            chk("oe_low_cycles", oe_cnt, RDW);
          end
          $display("done %s addr=%0h data=%04h at cycle %0d", mon_e.w ? "WR" : "RD",
                   sram_addr, mon_e.w ? mon_e.data : rdata, cyc);
        end
        oe_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  // ---------------- Stimulus ----------------
  int unsigned last_acc = 0;
  int unsigned last_gap = 0;
  bit          chain = 1'b0;

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] b, input bit abort);
    int          waited = 0;
    int unsigned acc;
    exp_t        e;
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wdata = d; be = b;
    while (!ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      chk("accept_timeout", {31'b0, ready}, 32'd1);
      req = 1'b0;
      chain = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (chain) chk("accept_gap", acc - last_acc, last_gap);
    chain    = 1'b1;
    last_acc = acc;
    last_gap = w ? (WRW + 3 + TRN) : rd_latency(RDW);
    if (!abort) begin
      e.w  = w;
      e.be = b;
      e.done_cyc = acc + (w ? (WRW + 2) : RDW);
      if (w) begin
        if (b[0]) model[a[7:0]][7:0]  = d[7:0];
        if (b[1]) model[a[7:0]][15:8] = d[15:8];
        e.data = d;
      end else begin
        e.data = model[a[7:0]];
      end
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req = 1'b0;
    chain = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic check_strobes_idle(input string tag);
    chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
    chk({tag, "_done"},  {31'b0, done},  32'd0);
    chk({tag, "_ce_n"},  {31'b0, ce_n},  32'd1);
    chk({tag, "_oe_n"},  {31'b0, oe_n},  32'd1);
    chk({tag, "_we_n"},  {31'b0, we_n},  32'd1);
    chk({tag, "_lb_ub"}, {30'b0, lb_n, ub_n}, 32'd3);
    chk({tag, "_dq_released"}, {31'b0, dut.u_dq_io.drive_reg}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = init_val(i);

    // Reset state.
    repeat (3) @(negedge clk);
    check_strobes_idle("reset");
    chk("reset_sram_addr", sram_addr, 32'd0);
    chk("reset_rdata", {16'b0, rdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_strobes_idle("post_reset");

    // Full write, read back, byte write, read back; Req held so gaps are checked.
    issue(1'b1, 20'h00010, 16'hBEEF, 2'b11, 1'b0);
    issue(1'b0, 20'h00010, 16'h0000, 2'b00, 1'b0);
    issue(1'b1, 20'h00010, 16'h1234, 2'b01, 1'b0);
    issue(1'b0, 20'h00010, 16'h0000, 2'b00, 1'b0);
    // Back-to-back reads.
    issue(1'b0, 20'h00010, 16'h0000, 2'b00, 1'b0);
    issue(1'b0, 20'h00003, 16'h0000, 2'b00, 1'b0);
    // No-lane write still completes, then read shows unchanged data.
    issue(1'b1, 20'h00003, 16'hFFFF, 2'b00, 1'b0);
    issue(1'b0, 20'h00003, 16'h0000, 2'b00, 1'b0);
    idle(3);

    // Reset during the write pulse aborts with no Done and no memory change.
    issue(1'b1, 20'h00010, 16'hA5A5, 2'b11, 1'b1);
    for (int k = 0; k < 10 && we_n; k++) @(negedge clk);
    chk("pulse_started", {31'b0, we_n}, 32'd0);
    rst_n = 1'b0;
    req = 1'b0;
    chain = 1'b0;
    #1;
    check_strobes_idle("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 20'h00010, 16'h0000, 2'b00, 1'b0);
    idle(2);

    // Randomized traffic over a small address window.
    for (int n = 0; n < 150; n++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 17)),
            16'($urandom), 2'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
